// File: rtl/cfg_serial_ctrl.sv
// Serial configuration write controller: shifts a word MSB-first on a shared sdata line, clocked by one selected ser_clk line.
// Latency: done is seen 2*CLK_DIV*B + CLK_DIV + 1 cycles after acceptance (B = shifted bits); err is seen 1 cycle after acceptance.
// Backpressure: req_ready is high only in IDLE; a request held valid is taken in the done cycle. Optional feature macro: CFG_SER_PARITY_EN.
module cfg_serial_ctrl #(
    parameter int DATA_W  = 32,
    parameter int NUM_CLK = 2,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_sel,
    input  logic [5:0]        req_len,
    input  logic [DATA_W-1:0] req_data,
    output logic              sdata,
    output logic [NUM_CLK-1:0] ser_clk,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_W + 2);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_t;

    state_t              state;
    logic [CW-1:0]       phase_cnt;
    logic [BW-1:0]       bit_idx;
    logic [DATA_W:0]     word_q;
    logic [NUM_CLK-1:0]  sel_mask_q;

    logic                legal;
    logic [DATA_W-1:0]   masked;
    logic [DATA_W:0]     word_nxt;
    logic [BW-1:0]       nbits;
    logic [NUM_CLK-1:0]  sel_mask;
    logic                phase_end;

    // Decode the incoming request: legality, masked word (plus parity bit when enabled) and line mask
    always_comb begin
        legal = (req_sel != 8'd0) && (int'(req_sel) <= NUM_CLK) &&
                (req_len != 6'd0) && (int'(req_len) <= DATA_W);
        masked = '0;
        for (int i = 0; i < DATA_W; i++) begin
            masked[i] = (i < int'(req_len)) ? req_data[i] : 1'b0;
        end
`ifdef CFG_SER_PARITY_EN
        // Parity bit goes last so the total count of ones on the wire is odd
        word_nxt = {masked, ~(^masked)};
        nbits    = BW'(req_len) + BW'(1);
`else
        word_nxt = {1'b0, masked};
        nbits    = BW'(req_len);
`endif
        sel_mask  = NUM_CLK'(1) << (req_sel - 8'd1);
        phase_end = (phase_cnt == CW'(CLK_DIV - 1));
    end

    // Single-process FSM; every output is a flop so the serial clocks never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            bit_idx    <= '0;
            word_q     <= '0;
            sel_mask_q <= '0;
            req_ready  <= 1'b1;
            sdata      <= 1'b0;
            ser_clk    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (legal) begin
                            state      <= LOW;
                            phase_cnt  <= '0;
                            word_q     <= word_nxt;
                            bit_idx    <= nbits - BW'(1);
                            sel_mask_q <= sel_mask;
                            sdata      <= word_nxt[nbits - BW'(1)];
                            busy       <= 1'b1;
                            req_ready  <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        ser_clk   <= sel_mask_q;
                        state     <= HIGH;
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        ser_clk   <= '0;
                        if (bit_idx == '0) begin
                            sdata <= 1'b0;
                            state <= HOLD;
                        end else begin
                            bit_idx <= bit_idx - BW'(1);
                            sdata   <= word_q[bit_idx - BW'(1)];
                            state   <= LOW;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_serial_ctrl.sv
module tb_cfg_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_sel = '0;
    logic [5:0]  req_len = '0;
    logic [31:0] req_data = '0;
    logic        sdata;
    logic [1:0]  ser_clk;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    cfg_serial_ctrl #(.DATA_W(32), .NUM_CLK(2), .CLK_DIV(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_sel  (req_sel),
        .req_len  (req_len),
        .req_data (req_data),
        .sdata    (sdata),
        .ser_clk  (ser_clk),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        int          len;
        logic [31:0] data;
        int          exp_err;
        logic [63:0] exp_bits;
        int          exp_edges;
        int          exp_done;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Watches the transfer from the cycle after acceptance (c=1) until done or maxc cycles
    task automatic monitor(input int sel, input int maxc,
                           output int done_c, output int err_c, output int edges,
                           output logic [63:0] bits, output int other_bad, output int ready_low);
        logic prev;
        logic [1:0] mask;
        prev = 1'b0;
        mask = (sel == 1) ? 2'b01 : (sel == 2) ? 2'b10 : 2'b00;
        done_c = 0; err_c = 0; edges = 0; bits = '0; other_bad = 0; ready_low = 0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if ((ser_clk & ~mask) != 2'b00) other_bad++;
            if (mask != 2'b00) begin
                if ((|(ser_clk & mask)) && !prev) begin
                    edges++;
                    bits = {bits[62:0], sdata};
                end
                prev = |(ser_clk & mask);
            end
            if (!req_ready) ready_low++;
            if (err && err_c == 0) err_c = c;
            if (done) begin
                done_c = c;
                break;
            end
        end
    endtask

    task automatic drive(input int sel, input int len, input logic [31:0] data);
        @(negedge clk);
        req_sel   = 8'(sel);
        req_len   = 6'(len);
        req_data  = data;
        req_valid = 1'b1;
    endtask

    int          d_c, e_c, n_e, o_b, r_l;
    logic [63:0] bits;

    initial begin
`ifdef CFG_SER_PARITY_EN
        vt[0] = '{1, 4,  32'h0000000A, 0, 64'h15,        5,  23};
        vt[6] = '{2, 1,  32'h00000001, 0, 64'h2,         2,  11};
        vt[7] = '{2, 8,  32'hFFFFFFC5, 0, 64'h18B,       9,  39};
        vt[8] = '{1, 32, 32'hDEADBEEF, 0, 64'h1BD5B7DDF, 33, 135};
        vt[5] = '{1, 3,  32'h00000005, 0, 64'hB,         4,  19};
`else
        vt[0] = '{1, 4,  32'h0000000A, 0, 64'hA,         4,  19};
        vt[6] = '{2, 1,  32'h00000001, 0, 64'h1,         1,  7};
        vt[7] = '{2, 8,  32'hFFFFFFC5, 0, 64'hC5,        8,  35};
        vt[8] = '{1, 32, 32'hDEADBEEF, 0, 64'hDEADBEEF,  32, 131};
        vt[5] = '{1, 3,  32'h00000005, 0, 64'h5,         3,  15};
`endif
        vt[1] = '{0, 8,  32'h000000FF, 1, 64'h0, 0, 0};
        vt[2] = '{3, 4,  32'h0000000F, 1, 64'h0, 0, 0};
        vt[3] = '{1, 0,  32'h0000000F, 1, 64'h0, 0, 0};
        vt[4] = '{2, 33, 32'h0000000F, 1, 64'h0, 0, 0};

        // Reset state, checked while rst is still high
        rst = 1'b1;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_sdata", 64'(sdata), 64'd0);
        chk("rst_serclk", 64'(ser_clk), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Table-driven single requests
        foreach (vt[i]) begin
            drive(vt[i].sel, vt[i].len, vt[i].data);
            chk($sformatf("v%0d_ready_before", i), 64'(req_ready), 64'd1);
            @(posedge clk);
            #1 req_valid = 1'b0;
            monitor(vt[i].sel, vt[i].exp_err ? 40 : 200, d_c, e_c, n_e, bits, o_b, r_l);
            chk($sformatf("v%0d_err_cycle", i), 64'(e_c), vt[i].exp_err ? 64'd1 : 64'd0);
            chk($sformatf("v%0d_done_cycle", i), 64'(d_c), 64'(vt[i].exp_done));
            chk($sformatf("v%0d_edges", i), 64'(n_e), 64'(vt[i].exp_edges));
            chk($sformatf("v%0d_bits", i), bits, vt[i].exp_bits);
            chk($sformatf("v%0d_other_lines", i), 64'(o_b), 64'd0);
            if (vt[i].exp_err != 0) begin
                chk($sformatf("v%0d_ready_stays", i), 64'(r_l), 64'd0);
            end else begin
                chk($sformatf("v%0d_idle_sdata", i), 64'(sdata), 64'd0);
                chk($sformatf("v%0d_idle_busy", i), 64'(busy), 64'd0);
            end
        end

        // Back-to-back: second request held valid during the first transfer
        drive(2, 32, 32'h80000001);
        @(posedge clk);
        #1;
        req_sel = 8'd1; req_len = 6'd1; req_data = 32'h1;
        monitor(2, 200, d_c, e_c, n_e, bits, o_b, r_l);
`ifdef CFG_SER_PARITY_EN
        chk("b2b_first_done", 64'(d_c), 64'd135);
        chk("b2b_first_bits", bits, 64'h100000003);
`else
        chk("b2b_first_done", 64'(d_c), 64'd131);
        chk("b2b_first_bits", bits, 64'h80000001);
`endif
        chk("b2b_first_other", 64'(o_b), 64'd0);
        chk("b2b_ready_in_done", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        monitor(1, 60, d_c, e_c, n_e, bits, o_b, r_l);
`ifdef CFG_SER_PARITY_EN
        chk("b2b_second_done", 64'(d_c), 64'd11);
        chk("b2b_second_bits", bits, 64'h2);
`else
        chk("b2b_second_done", 64'(d_c), 64'd7);
        chk("b2b_second_bits", bits, 64'h1);
`endif
        chk("b2b_second_busy_first", 64'(r_l > 0), 64'd1);

        // Reset after two bits of a len=8 transfer
        drive(1, 8, 32'hFF);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_e = 0;
        begin
            logic prev;
            prev = 1'b0;
            for (int c = 0; c < 100 && n_e < 2; c++) begin
                @(negedge clk);
                if (ser_clk[0] && !prev) n_e++;
                prev = ser_clk[0];
            end
        end
        chk("midrst_two_edges", 64'(n_e), 64'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_sdata", 64'(sdata), 64'd0);
        chk("midrst_serclk", 64'(ser_clk), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        monitor(1, 30, d_c, e_c, n_e, bits, o_b, r_l);
        chk("midrst_no_done", 64'(d_c), 64'd0);
        drive(1, 4, 32'hA);
        @(posedge clk);
        #1 req_valid = 1'b0;
        monitor(1, 100, d_c, e_c, n_e, bits, o_b, r_l);
`ifdef CFG_SER_PARITY_EN
        chk("postrst_done", 64'(d_c), 64'd23);
        chk("postrst_bits", bits, 64'h15);
`else
        chk("postrst_done", 64'(d_c), 64'd19);
        chk("postrst_bits", bits, 64'hA);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cfg_serial_ctrl.md
CFG_SERIAL_CTRL -- requirements
Module: cfg_serial_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: maximum configuration word width in bits.
REQ-002 Parameter NUM_CLK, default 2: number of per-register serial clock lines.
REQ-003 Parameter CLK_DIV, default 2: serial clock half-period in clk cycles (>=1).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  configuration write request.
REQ-007 req_ready  output  1  controller idle and able to accept a request.
REQ-008 req_sel  input  8  target register; serial clock line sel-1 is used; 0 (shared sdata index) is illegal.
REQ-009 req_len  input  6  number of bits to shift, legal range 1..DATA_W.
REQ-010 req_data  input  DATA_W  word to shift, LSB-aligned; bit req_len-1 is sent first.
REQ-011 sdata  output  1  serial data shared by all configuration registers.
REQ-012 ser_clk  output  NUM_CLK  per-register serial clocks (line 0 = mask_clk).
REQ-013 busy  output  1  shift in progress.
REQ-014 done  output  1  one-cycle pulse when a write completes.
REQ-015 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-016 The controller SHALL accept a request on a clk edge where req_valid and req_ready are both 1, capturing sel, len and data.
REQ-017 req_ready SHALL be 1 exactly when the FSM is in IDLE; req_* SHALL be ignored otherwise.
REQ-018 FSM states SHALL be IDLE, LOW, HIGH, HOLD; all transitions occur on clk edges.
REQ-019 Illegal request (sel=0, sel>NUM_CLK, len=0 or len>DATA_W) SHALL pulse err in the cycle after acceptance, remain in IDLE, and toggle no output.
REQ-020 Legal request: IDLE->LOW; sdata SHALL present the current bit for the whole LOW phase (CLK_DIV cycles), with ser_clk[sel-1]=0.
REQ-021 HIGH phase: ser_clk[sel-1]=1 for CLK_DIV cycles, sdata unchanged; then LOW for the next bit, or HOLD after the last bit.
REQ-022 HOLD: sdata=0, all ser_clk=0 for CLK_DIV cycles; then IDLE with done=1 in that same first IDLE cycle.
REQ-023 For B shifted bits, done SHALL assert exactly 2*CLK_DIV*B + CLK_DIV + 1 cycles after the acceptance edge.
REQ-024 Unselected ser_clk lines SHALL stay 0 throughout; sdata SHALL be 0 in IDLE.
REQ-025 busy SHALL be 1 in LOW, HIGH and HOLD, 0 in IDLE.
REQ-026 A request held valid during busy SHALL be accepted in the done cycle (back-to-back, no dead cycle).
REQ-027 Bit and phase counters SHALL be sized for DATA_W+1 bits and CLK_DIV; no wrap-around within a transfer.
REQ-028 All outputs SHALL be registered (glitch-free serial clocks).

Reset
REQ-029 While rst=1: state IDLE, req_ready=1, sdata=0, ser_clk=0, busy=0, done=0, err=0, asynchronously.
REQ-030 rst asserted mid-transfer SHALL abort it immediately with no done pulse; the next request after release SHALL run normally.

Configuration
REQ-031 Macro CFG_SER_PARITY_EN defined: after the last data bit, one extra bit SHALL be shifted, making the count of ones across all shifted bits odd (B=len+1).
REQ-032 Macro CFG_SER_PARITY_EN undefined: exactly len bits SHALL be shifted (B=len); no parity logic is present.

Verification (DATA_W=32, NUM_CLK=2, CLK_DIV=2, parity off unless stated)
REQ-033 Reset: rst pulse -> req_ready=1, sdata=0, ser_clk=2'b00, busy/done/err=0.
REQ-034 sel=1, len=4, data=0xA -> sdata 1,0,1,0; 4 rising edges on ser_clk[0], ser_clk[1]=0; done 19 cycles after acceptance.
REQ-035 sel=0, len=8 -> err pulse 1 cycle after acceptance, no ser_clk edges, req_ready stays 1, no done.
REQ-036 sel=2, len=32, data=0x80000001, second request (sel=1, len=1) held valid -> 32 edges on ser_clk[1], first/last bit 1; second request accepted in done cycle at +131, its done at +7.
REQ-037 rst asserted after 2 bits of a len=8 transfer -> sdata, ser_clk, busy 0 immediately, no done; next len=4 request completes at +19.
REQ-038 CFG_SER_PARITY_EN defined, sel=1, len=3, data=3'b101 -> sdata 1,0,1,1; 4 edges; done 19 cycles after acceptance.
